capture_stream_controller: RTL and testbench

Sequences data capture from the sample source into the FIFO→BRAM ring buffer and manages the PS readout handshake. It runs a start/stop/drain state machine and gates source writes into the FIFO with backpressure margin. It tracks the BRAM write address to raise ping-pong half-buffer interrupts, counts outstanding halves against PS acknowledgements, and flags overflow. It sits between the sample source and the FIFO/BRAM interface; control and status are exposed to PS registers.

---
 rtl/capture_stream_controller.sv | 140 ++++++++++++++
 tb/tb_capture_stream_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_stream_controller.sv
// Capture sequencer between the sample source and the FIFO->BRAM ring buffer:
// start/stop/drain FSM, backpressure gating, ping-pong half interrupts and overflow tracking.
module capture_stream_controller #(
  parameter int BRAM_DEPTH_WORDS = 8192,
  parameter int FIFO_DEPTH       = 256,
  parameter int FIFO_MARGIN      = 4,
  parameter int ADDR_W           = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              ctrl_clear,
  input  logic              ps_ack_half,
  input  logic              src_valid,
  input  logic [63:0]       src_data,
  output logic              src_ready,
  output logic              fifo_write_en,
  output logic [63:0]       fifo_write_data,
  input  logic [8:0]        fifo_count,
  input  logic [ADDR_W-1:0] current_bram_address,
  output logic [1:0]        state,
  output logic              irq_half,
  output logic              half_index,
  output logic [1:0]        halves_pending,
  output logic              overflow,
  output logic              capture_done,
  output logic [31:0]       words_captured,
  output logic [15:0]       dropped_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] HALF_ADDR   = ADDR_W'(BRAM_DEPTH_WORDS / 2);
  localparam logic [9:0]        READY_LIMIT = 10'(FIFO_DEPTH - FIFO_MARGIN);

  state_t            st;
  logic [ADDR_W-1:0] prev_addr;
  logic              zero_seen;
  logic              crossing;
  logic              cross_upper;
  logic              ack_eff;
  logic              ovf_event;
  logic              clear_ok;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign state = st;

  // Reset gates acceptance so a word presented during reset is never written.
  assign src_ready       = !rst && (st == RUN) && ({1'b0, fifo_count} < READY_LIMIT);
  assign fifo_write_en   = src_valid && src_ready;
  assign fifo_write_data = src_data;

  assign cross_upper = (current_bram_address == '0);
  assign crossing    = (current_bram_address != prev_addr) &&
                       ((current_bram_address == HALF_ADDR) || cross_upper);
  assign ack_eff     = ps_ack_half && ((halves_pending != 2'd0) || crossing);
  assign ovf_event   = crossing && !ack_eff && (halves_pending == 2'd2);
  assign clear_ok    = ctrl_clear && ((st == IDLE) || (st == FAULT));

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      prev_addr      <= '0;
      zero_seen      <= 1'b0;
      irq_half       <= 1'b0;
      half_index     <= 1'b0;
      halves_pending <= 2'd0;
      overflow       <= 1'b0;
      capture_done   <= 1'b0;
      words_captured <= 32'd0;
      dropped_count  <= 16'd0;
    end else begin
      prev_addr    <= current_bram_address;
      irq_half     <= crossing;
      capture_done <= 1'b0;
      zero_seen    <= (st == DRAIN) && (fifo_count == 9'd0);

      if (crossing)
        half_index <= cross_upper;

      if (fifo_write_en)
        words_captured <= words_captured + 32'd1;

      if ((st == RUN) && src_valid && !src_ready)
        dropped_count <= sat_inc16(dropped_count);

      // A crossing and an ack in the same cycle cancel out.
      if (crossing && !ack_eff) begin
        if (halves_pending == 2'd2)
          overflow <= 1'b1;
        else
          halves_pending <= halves_pending + 2'd1;
      end else if (!crossing && ack_eff) begin
        halves_pending <= halves_pending - 2'd1;
      end

      case (st)
        IDLE: begin
          if (!ctrl_clear && ctrl_start) begin
            st             <= RUN;
            words_captured <= 32'd0;
          end
        end
        RUN: begin
          if (ovf_event)
            st <= FAULT;
          else if (ctrl_stop)
            st <= DRAIN;
        end
        DRAIN: begin
          if (ovf_event) begin
            st <= FAULT;
          end else if (zero_seen && (fifo_count == 9'd0)) begin
            st           <= IDLE;
            capture_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (clear_ok) begin
        st             <= IDLE;
        overflow       <= 1'b0;
        halves_pending <= 2'd0;
        dropped_count  <= 16'd0;
        half_index     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_stream_controller.sv
// Scoreboard bench for capture_stream_controller: directed stimulus pushes expected
// FIFO writes, half interrupts and drain completions; a negedge monitor pops and compares.
module tb_capture_stream_controller;

  logic        clk;
  logic        rst;
  logic        ctrl_start, ctrl_stop, ctrl_clear, ps_ack_half;
  logic        src_valid;
  logic [63:0] src_data;
  logic        src_ready;
  logic        fifo_write_en;
  logic [63:0] fifo_write_data;
  logic [8:0]  fifo_count;
  logic [12:0] current_bram_address;
  logic [1:0]  state;
  logic        irq_half, half_index;
  logic [1:0]  halves_pending;
  logic        overflow, capture_done;
  logic [31:0] words_captured;
  logic [15:0] dropped_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int exp_done = 0;
  logic [63:0] exp_data[$];
  logic        exp_half[$];

  capture_stream_controller #(
    .BRAM_DEPTH_WORDS(8192),
    .FIFO_DEPTH(256),
    .FIFO_MARGIN(4),
    .ADDR_W(13)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_start(ctrl_start),
    .ctrl_stop(ctrl_stop),
    .ctrl_clear(ctrl_clear),
    .ps_ack_half(ps_ack_half),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .fifo_write_en(fifo_write_en),
    .fifo_write_data(fifo_write_data),
    .fifo_count(fifo_count),
    .current_bram_address(current_bram_address),
    .state(state),
    .irq_half(irq_half),
    .half_index(half_index),
    .halves_pending(halves_pending),
    .overflow(overflow),
    .capture_done(capture_done),
    .words_captured(words_captured),
    .dropped_count(dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_write_en) begin
        n_writes++;
        if (exp_data.size() == 0) unexpected("wr_data");
        else check("wr_data", fifo_write_data, exp_data.pop_front());
      end
      if (irq_half) begin
        if (exp_half.size() == 0) unexpected("irq_half");
        else check("half_index", {63'd0, half_index}, {63'd0, exp_half.pop_front()});
      end
      if (capture_done) begin
        n_checks++;
        if (exp_done == 0) begin
          n_fail++;
          $display("FAIL capture_done: pulse seen, expected none (state %0d)", state);
        end else begin
          exp_done--;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, state %0d", state);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ctrl_start = 0; ctrl_stop = 0; ctrl_clear = 0; ps_ack_half = 0;
    src_valid = 0; src_data = '0; fifo_count = '0; current_bram_address = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_words", words_captured, 0);
    check("rst_dropped", dropped_count, 0);
    check("rst_pending", halves_pending, 0);
    check("rst_overflow", overflow, 0);
    check("rst_src_ready", src_ready, 0);

    // Capture 100 words with an always-empty FIFO.
    ctrl_start = 1; tick(); ctrl_start = 0;
    check("start_state", state, 1);
    for (int i = 0; i < 100; i++) begin
      src_valid = 1;
      src_data  = 64'hA500_0000_0000_0000 + 64'(i * 3);
      exp_data.push_back(src_data);
      tick();
    end
    src_valid = 0;
    check("run_words", words_captured, 100);
    check("run_dropped", dropped_count, 0);
    check("run_state", state, 1);
    check("run_writes", n_writes, 100);

    // Stop with 5 words in the FIFO draining one per cycle.
    fifo_count = 9'd5;
    ctrl_stop = 1; tick(); ctrl_stop = 0;
    check("stop_state", state, 2);
    exp_done = 1;
    for (int i = 1; i <= 6; i++) begin
      if (fifo_count != 0) fifo_count = fifo_count - 9'd1;
      tick();
      check($sformatf("drain_state_%0d", i), state, (i < 6) ? 2 : 0);
    end
    tick();
    check("done_consumed", exp_done, 0);

    // Half crossings at 4096 and 0.
    current_bram_address = 13'd4095; tick();
    current_bram_address = 13'd4096; exp_half.push_back(1'b0); tick();
    check("irq_lower", irq_half, 1);
    tick();
    check("irq_one_cycle", irq_half, 0);
    current_bram_address = 13'd8191; tick();
    current_bram_address = 13'd0; exp_half.push_back(1'b1); tick();
    check("irq_upper_idx", half_index, 1);
    check("pending_two", halves_pending, 2);

    // Third crossing in RUN without ack -> overflow and FAULT.
    ctrl_start = 1; tick(); ctrl_start = 0;
    check("restart_words", words_captured, 0);
    current_bram_address = 13'd4096; exp_half.push_back(1'b0); tick();
    check("ovf_flag", overflow, 1);
    check("ovf_state", state, 3);
    check("ovf_pending", halves_pending, 2);
    src_valid = 1; #1;
    check("fault_src_ready", src_ready, 0);
    check("fault_wr_en", fifo_write_en, 0);
    src_valid = 0;
    ctrl_clear = 1; tick(); ctrl_clear = 0;
    check("clr_state", state, 0);
    check("clr_overflow", overflow, 0);
    check("clr_pending", halves_pending, 0);
    check("clr_half_index", half_index, 0);

    // Crossing coincident with an ack at pending=2, then acks down to zero.
    current_bram_address = 13'd0;    exp_half.push_back(1'b1); tick();
    current_bram_address = 13'd4096; exp_half.push_back(1'b0); tick();
    check("pend_refill", halves_pending, 2);
    current_bram_address = 13'd0; ps_ack_half = 1; exp_half.push_back(1'b1); tick();
    ps_ack_half = 0;
    check("coinc_pending", halves_pending, 2);
    check("coinc_overflow", overflow, 0);
    ps_ack_half = 1; tick();
    check("ack_pending1", halves_pending, 1);
    tick(); tick();
    ps_ack_half = 0;
    check("ack_at_zero", halves_pending, 0);

    // Start and stop together in IDLE, then backpressure at the margin.
    ctrl_start = 1; ctrl_stop = 1; tick(); ctrl_start = 0; ctrl_stop = 0;
    check("start_stop_state", state, 1);
    fifo_count = 9'd252;
    src_valid = 1;
    #1;
    check("margin_src_ready", src_ready, 0);
    for (int i = 0; i < 10; i++) tick();
    src_valid = 0;
    check("margin_dropped", dropped_count, 10);
    check("margin_words", words_captured, 0);
    fifo_count = 9'd251; #1;
    check("below_margin_ready", src_ready, 1);

    // Reset mid-capture: in-flight word must not be written.
    fifo_count = 9'd0;
    src_valid = 1; src_data = 64'hDEAD_BEEF_0000_0001;
    rst = 1; #1;
    check("rst_wr_en", fifo_write_en, 0);
    tick();
    rst = 0; src_valid = 0; #1;
    check("midrst_state", state, 0);
    check("midrst_dropped", dropped_count, 0);
    check("midrst_words", words_captured, 0);
    check("midrst_pending", halves_pending, 0);
    tick();

    check("sb_data_empty", exp_data.size(), 0);
    check("sb_half_empty", exp_half.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
